// File: rtl/issue_queue_int_pkg.sv
// issue_queue_int_pkg: default widths and entry field layout shared by the
// integer, ld/st, mul and div issue queues.
package issue_queue_int_pkg;

    localparam int IQ_DATA_WIDTH   = 32;
    localparam int IQ_TAG_WIDTH    = 6;
    localparam int IQ_OPCODE_WIDTH = 4;

    typedef struct packed {
        logic                       valid;
        logic [IQ_OPCODE_WIDTH-1:0] opcode;
        logic [IQ_TAG_WIDTH-1:0]    rd_tag;
        logic                       pend1;
        logic [IQ_TAG_WIDTH-1:0]    tag1;
        logic [IQ_DATA_WIDTH-1:0]   data1;
        logic                       pend2;
        logic [IQ_TAG_WIDTH-1:0]    tag2;
        logic [IQ_DATA_WIDTH-1:0]   data2;
    } iq_entry_t;

endpackage

// File: rtl/issue_queue_int_oldest_select.sv
// issueq_oldest_select: lowest-index (oldest) priority picker with one-hot grant.
module issueq_oldest_select
    import issue_queue_int_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant,
    output logic             select_valid
);

    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = req[i] && !found;
            found    = found || req[i];
        end
        select_valid = |req;
    end

endmodule

// File: rtl/issue_queue_int.sv
// issue_queue_int: age-ordered compacting integer reservation station with CDB wakeup.
// Optional ISSUEQ_CDB_WAKEUP_BYPASS_EN lets select use the live CDB for pending operands.
module issue_queue_int
    import issue_queue_int_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int DATA_WIDTH   = IQ_DATA_WIDTH,
    parameter int TAG_WIDTH    = IQ_TAG_WIDTH,
    parameter int OPCODE_WIDTH = IQ_OPCODE_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    dispatch_en_integer,
    input  logic [OPCODE_WIDTH-1:0] dispatch_opcode,
    input  logic [TAG_WIDTH-1:0]    dispatch_rd_tag,
    input  logic [DATA_WIDTH-1:0]   dispatch_rs1_data,
    input  logic [TAG_WIDTH-1:0]    dispatch_rs1_tag,
    input  logic                    dispatch_rs1_valid,
    input  logic [DATA_WIDTH-1:0]   dispatch_rs2_data,
    input  logic [TAG_WIDTH-1:0]    dispatch_rs2_tag,
    input  logic                    dispatch_rs2_valid,
    input  logic                    cdb_valid,
    input  logic [TAG_WIDTH-1:0]    cdb_tag,
    input  logic [DATA_WIDTH-1:0]   cdb_data,
    input  logic                    issue_ready,
    output logic                    issue_valid,
    output logic [OPCODE_WIDTH-1:0] issue_opcode,
    output logic [TAG_WIDTH-1:0]    issue_rd_tag,
    output logic [DATA_WIDTH-1:0]   issue_rs1_data,
    output logic [DATA_WIDTH-1:0]   issue_rs2_data,
    output logic                    issueque_full_integer
);

`ifdef ISSUEQ_CDB_WAKEUP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DEPTH-1:0]        valid, p1, p2;
    logic [OPCODE_WIDTH-1:0] op [DEPTH];
    logic [TAG_WIDTH-1:0]    rd [DEPTH];
    logic [TAG_WIDTH-1:0]    t1 [DEPTH];
    logic [TAG_WIDTH-1:0]    t2 [DEPTH];
    logic [DATA_WIDTH-1:0]   d1 [DEPTH];
    logic [DATA_WIDTH-1:0]   d2 [DEPTH];

    // Entries after same-edge wakeup; the extra top slot is an empty filler for shifting.
    logic [DEPTH:0]          w_valid, w_p1, w_p2;
    logic [OPCODE_WIDTH-1:0] w_op [DEPTH+1];
    logic [TAG_WIDTH-1:0]    w_rd [DEPTH+1];
    logic [TAG_WIDTH-1:0]    w_t1 [DEPTH+1];
    logic [TAG_WIDTH-1:0]    w_t2 [DEPTH+1];
    logic [DATA_WIDTH-1:0]   w_d1 [DEPTH+1];
    logic [DATA_WIDTH-1:0]   w_d2 [DEPTH+1];

    logic [DEPTH-1:0]        n_valid, n_p1, n_p2;
    logic [OPCODE_WIDTH-1:0] n_op [DEPTH];
    logic [TAG_WIDTH-1:0]    n_rd [DEPTH];
    logic [TAG_WIDTH-1:0]    n_t1 [DEPTH];
    logic [TAG_WIDTH-1:0]    n_t2 [DEPTH];
    logic [DATA_WIDTH-1:0]   n_d1 [DEPTH];
    logic [DATA_WIDTH-1:0]   n_d2 [DEPTH];

    logic [DEPTH-1:0]        m1, m2, req, grant;
    logic                    sel_valid, load, remove, disp, cap1, cap2;
    logic [OPCODE_WIDTH-1:0] s_op;
    logic [TAG_WIDTH-1:0]    s_rd;
    logic [DATA_WIDTH-1:0]   s_d1, s_d2;

    assign issueque_full_integer = valid[DEPTH-1];

    always_comb begin
        w_valid        = {1'b0, valid};
        w_p1           = '0;
        w_p2           = '0;
        w_op[DEPTH]    = '0;
        w_rd[DEPTH]    = '0;
        w_t1[DEPTH]    = '0;
        w_t2[DEPTH]    = '0;
        w_d1[DEPTH]    = '0;
        w_d2[DEPTH]    = '0;
        m1             = '0;
        m2             = '0;
        req            = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m1[i]   = cdb_valid && (t1[i] == cdb_tag);
            m2[i]   = cdb_valid && (t2[i] == cdb_tag);
            w_op[i] = op[i];
            w_rd[i] = rd[i];
            w_t1[i] = t1[i];
            w_t2[i] = t2[i];
            w_p1[i] = p1[i] && !m1[i];
            w_p2[i] = p2[i] && !m2[i];
            w_d1[i] = (p1[i] && m1[i]) ? cdb_data : d1[i];
            w_d2[i] = (p2[i] && m2[i]) ? cdb_data : d2[i];
            req[i]  = valid[i] && (!p1[i] || (BYPASS && m1[i])) && (!p2[i] || (BYPASS && m2[i]));
        end
    end

    issueq_oldest_select #(.DEPTH(DEPTH)) u_select (
        .req          (req),
        .grant        (grant),
        .select_valid (sel_valid)
    );

    always_comb begin
        logic seen, placed, sh;
        load   = !issue_valid || issue_ready;
        remove = load && sel_valid;
        disp   = dispatch_en_integer && !valid[DEPTH-1];
        cap1   = dispatch_rs1_valid && cdb_valid && (dispatch_rs1_tag == cdb_tag);
        cap2   = dispatch_rs2_valid && cdb_valid && (dispatch_rs2_tag == cdb_tag);
        seen   = 1'b0;
        placed = 1'b0;
        sh     = 1'b0;
        s_op   = '0;
        s_rd   = '0;
        s_d1   = '0;
        s_d2   = '0;
        n_valid = '0;
        n_p1    = '0;
        n_p2    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            s_op = s_op | ({OPCODE_WIDTH{grant[i]}} & w_op[i]);
            s_rd = s_rd | ({TAG_WIDTH{grant[i]}} & w_rd[i]);
            s_d1 = s_d1 | ({DATA_WIDTH{grant[i]}} & w_d1[i]);
            s_d2 = s_d2 | ({DATA_WIDTH{grant[i]}} & w_d2[i]);
            // Everything at or above the removed entry moves down one slot.
            seen       = seen || grant[i];
            sh         = remove && seen;
            n_valid[i] = sh ? w_valid[i+1] : w_valid[i];
            n_p1[i]    = sh ? w_p1[i+1] : w_p1[i];
            n_p2[i]    = sh ? w_p2[i+1] : w_p2[i];
            n_op[i]    = sh ? w_op[i+1] : w_op[i];
            n_rd[i]    = sh ? w_rd[i+1] : w_rd[i];
            n_t1[i]    = sh ? w_t1[i+1] : w_t1[i];
            n_t2[i]    = sh ? w_t2[i+1] : w_t2[i];
            n_d1[i]    = sh ? w_d1[i+1] : w_d1[i];
            n_d2[i]    = sh ? w_d2[i+1] : w_d2[i];
            if (disp && !placed && !n_valid[i]) begin
                n_valid[i] = 1'b1;
                n_op[i]    = dispatch_opcode;
                n_rd[i]    = dispatch_rd_tag;
                n_t1[i]    = dispatch_rs1_tag;
                n_t2[i]    = dispatch_rs2_tag;
                n_p1[i]    = dispatch_rs1_valid && !cap1;
                n_p2[i]    = dispatch_rs2_valid && !cap2;
                n_d1[i]    = cap1 ? cdb_data : dispatch_rs1_data;
                n_d2[i]    = cap2 ? cdb_data : dispatch_rs2_data;
                placed     = 1'b1;
            end
        end
        if (flush) n_valid = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            p1    <= '0;
            p2    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op[i] <= '0;
                rd[i] <= '0;
                t1[i] <= '0;
                t2[i] <= '0;
                d1[i] <= '0;
                d2[i] <= '0;
            end
            issue_valid    <= 1'b0;
            issue_opcode   <= '0;
            issue_rd_tag   <= '0;
            issue_rs1_data <= '0;
            issue_rs2_data <= '0;
        end else begin
            valid <= n_valid;
            p1    <= n_p1;
            p2    <= n_p2;
            op    <= n_op;
            rd    <= n_rd;
            t1    <= n_t1;
            t2    <= n_t2;
            d1    <= n_d1;
            d2    <= n_d2;
            if (flush) begin
                issue_valid <= 1'b0;
            end else if (load) begin
                issue_valid <= sel_valid;
                if (sel_valid) begin
                    issue_opcode   <= s_op;
                    issue_rd_tag   <= s_rd;
                    issue_rs1_data <= s_d1;
                    issue_rs2_data <= s_d2;
                end
            end
        end
    end

endmodule
